// File: rtl/window_serializer_if.sv
// Handshake bundle between the pyramid levels (window side) and the classifier (word side).
// The serializer attaches to the slave modport; the source/sink side uses master.
interface window_serializer_if #(
    parameter int WINDOW_WIDTH = 1152,
    parameter int LEVELS       = 15,
    parameter int WORD_WIDTH   = 32
);
    localparam int LEVEL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    logic [LEVELS-1:0]              window_valid;
    logic [LEVELS*WINDOW_WIDTH-1:0] detection_window;
    logic [LEVELS-1:0]              window_ready;
    logic [WORD_WIDTH-1:0]          word_out;
    logic                           word_valid;
    logic                           word_ready;
    logic [LEVEL_W-1:0]             word_level;
    logic                           word_first;
    logic                           word_last;

    modport master (
        output window_valid, detection_window, word_ready,
        input  window_ready, word_out, word_valid, word_level, word_first, word_last
    );

    modport slave (
        input  window_valid, detection_window, word_ready,
        output window_ready, word_out, word_valid, word_level, word_first, word_last
    );
endinterface

// File: rtl/window_serializer.sv
// Round-robin funnel: captures one detection window from any pyramid level and
// streams it out word by word with level tag and first/last markers.
module window_serializer #(
    parameter int WINDOW_WIDTH = 1152,
    parameter int LEVELS       = 15,
    parameter int WORD_WIDTH   = 32
) (
    input logic               clk,
    input logic               rst,
    window_serializer_if.slave bus
);
    localparam int NUM_WORDS = WINDOW_WIDTH / WORD_WIDTH;
    localparam int LEVEL_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q, state_d;
    logic [LEVEL_W-1:0]        ptr_q;
    logic [LEVEL_W-1:0]        level_q;
    logic [IDX_W-1:0]          idx_q;
    logic [WINDOW_WIDTH-1:0]   buffer_q;

    logic [LEVEL_W-1:0]        grant;
    logic                      grant_found;
    logic                      accept;
    logic                      xfer;
    logic                      is_send;
    logic                      is_last;

    // First pending level at or after ptr, wrapping; the just-served level sits last.
    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            j = (int'(ptr_q) + i) % LEVELS;
            if (!grant_found && bus.window_valid[LEVEL_W'(j)]) begin
                grant_found = 1'b1;
                grant       = LEVEL_W'(j);
            end
        end
    end

    assign is_send = (state_q == SEND);
    assign is_last = (idx_q == IDX_W'(NUM_WORDS - 1));

    always_comb begin
        state_d          = state_q;
        bus.window_ready = '0;
        accept           = 1'b0;
        xfer             = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    bus.window_ready[grant] = 1'b1;
                    accept                  = 1'b1;
                    state_d                 = SEND;
                end
            end
            SEND: begin
                if (bus.word_ready) begin
                    xfer = 1'b1;
                    if (is_last)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            buffer_q <= '0;
        end else if (accept) begin
            buffer_q <= bus.detection_window[grant*WINDOW_WIDTH +: WINDOW_WIDTH];
            level_q  <= grant;
            idx_q    <= '0;
        end else if (xfer) begin
            if (is_last) begin
                idx_q <= '0;
                ptr_q <= (level_q == LEVEL_W'(LEVELS - 1)) ? '0 : level_q + 1'b1;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Word-side outputs are pure functions of registered state, so they hold while stalled.
    assign bus.word_valid = is_send;
    assign bus.word_out   = is_send ? buffer_q[idx_q*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign bus.word_level = level_q;
    assign bus.word_first = is_send && (idx_q == '0);
    assign bus.word_last  = is_send && is_last;
endmodule

// File: tb/tb_window_serializer.sv
// Directed bench for window_serializer: table-driven single window plus
// hand-written round-robin, wrap, stall, data-change and mid-window reset sequences.
module tb_window_serializer;
    localparam int WW  = 1152;
    localparam int LV  = 15;
    localparam int WDW = 32;
    localparam int NW  = WW / WDW;
    localparam int LW  = 4;

    typedef struct {
        logic [LV-1:0]  valid;
        logic           rdy;
        logic [LV-1:0]  e_wready;
        logic           e_wvalid;
        logic [WDW-1:0] e_out;
        logic           e_first;
        logic           e_last;
        logic [LW-1:0]  e_level;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [LV-1:0][WW-1:0] dw;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    logic [7:0] lfsr = 8'hA7;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window_serializer_if #(.WINDOW_WIDTH(WW), .LEVELS(LV), .WORD_WIDTH(WDW)) bus();

    window_serializer #(.WINDOW_WIDTH(WW), .LEVELS(LV), .WORD_WIDTH(WDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.detection_window = dw;

    function automatic logic [WW-1:0] mk_window(int lvl, int seed);
        logic [WW-1:0] w;
        for (int i = 0; i < NW; i++)
            w[i*WDW +: WDW] = {8'(seed), 8'(lvl), 16'(i)};
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        bus.window_valid = '0;
        bus.word_ready   = 1'b0;
        #1;
        chk("rst_wready", bus.window_ready, 0);
        chk("rst_wvalid", bus.word_valid, 0);
        chk("rst_out",    bus.word_out, 0);
        chk("rst_level",  bus.word_level, 0);
        chk("rst_first",  bus.word_first, 0);
        chk("rst_last",   bus.word_last, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic expect_accept(input logic [LV-1:0] vmask, input int lvl, input string nm);
        step();
        bus.window_valid = vmask;
        bus.word_ready   = 1'b1;
        #1;
        chk({nm, "_wready"}, bus.window_ready, 64'(1) << lvl);
        chk({nm, "_idle_wvalid"}, bus.word_valid, 0);
        last_acc = cyc;
    endtask

    // Runs one window's word phase; stops early after abort_at transfers when abort_at >= 0.
    task automatic expect_window(input logic [LV-1:0] vmask, input int lvl, input logic [WW-1:0] win,
                                 input bit stall, input bit mutate, input int abort_at, input string nm);
        int i = 0;
        int guard = 0;
        logic rdy;
        while (i < NW && i != abort_at && guard < 400) begin
            step();
            bus.window_valid = vmask;
            if (stall) begin
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                rdy  = lfsr[0];
            end else begin
                rdy = 1'b1;
            end
            bus.word_ready = rdy;
            if (mutate && i == 3)
                dw[lvl] = mk_window(lvl, 9);
            #1;
            chk({nm, "_wready"}, bus.window_ready, 0);
            chk({nm, "_wvalid"}, bus.word_valid, 1);
            chk({nm, "_out"},    bus.word_out, win[i*WDW +: WDW]);
            chk({nm, "_first"},  bus.word_first, (i == 0));
            chk({nm, "_last"},   bus.word_last, (i == NW - 1));
            chk({nm, "_level"},  bus.word_level, lvl);
            if (rdy) i++;
            guard++;
        end
        if (i < NW && i != abort_at) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: %0d words seen, expected %0d", nm, i, NW);
        end
    endtask

    vec_t tbl[NW + 3];

    initial begin
        int a_prev;
        logic [LV-1:0] m;

        bus.window_valid = '0;
        bus.word_ready   = 1'b0;
        for (int l = 0; l < LV; l++)
            dw[l] = mk_window(l, 0);

        // Single level-0 window, word i == i, consumer always ready.
        tbl[0] = '{valid: '0, rdy: 1'b1, e_wready: '0, e_wvalid: 1'b0, e_out: '0,
                   e_first: 1'b0, e_last: 1'b0, e_level: '0};
        tbl[1] = '{valid: 15'd1, rdy: 1'b1, e_wready: 15'd1, e_wvalid: 1'b0, e_out: '0,
                   e_first: 1'b0, e_last: 1'b0, e_level: '0};
        for (int i = 0; i < NW; i++)
            tbl[2+i] = '{valid: '0, rdy: 1'b1, e_wready: '0, e_wvalid: 1'b1, e_out: WDW'(i),
                         e_first: (i == 0), e_last: (i == NW - 1), e_level: '0};
        tbl[NW+2] = '{valid: '0, rdy: 1'b1, e_wready: '0, e_wvalid: 1'b0, e_out: '0,
                      e_first: 1'b0, e_last: 1'b0, e_level: '0};

        do_reset();
        for (int k = 0; k < NW + 3; k++) begin
            step();
            bus.window_valid = tbl[k].valid;
            bus.word_ready   = tbl[k].rdy;
            #1;
            chk("tbl_wready", bus.window_ready, tbl[k].e_wready);
            chk("tbl_wvalid", bus.word_valid, tbl[k].e_wvalid);
            chk("tbl_level",  bus.word_level, tbl[k].e_level);
            if (tbl[k].e_wvalid) begin
                chk("tbl_out",   bus.word_out, tbl[k].e_out);
                chk("tbl_first", bus.word_first, tbl[k].e_first);
                chk("tbl_last",  bus.word_last, tbl[k].e_last);
            end
        end

        // Levels 0, 3, 14 held: order 0, 3, 14, 0 at 37-cycle spacing; level 3 data changes mid-send.
        do_reset();
        m = LV'((1 << 0) | (1 << 3) | (1 << 14));
        expect_accept(m, 0, "rr0");
        a_prev = last_acc;
        expect_window(m, 0, mk_window(0, 0), 1'b0, 1'b0, -1, "rr0");
        expect_accept(m, 3, "rr3");
        chk("rr3_period", last_acc - a_prev, NW + 1);
        a_prev = last_acc;
        expect_window(m, 3, mk_window(3, 0), 1'b0, 1'b1, -1, "rr3");
        expect_accept(m, 14, "rr14");
        chk("rr14_period", last_acc - a_prev, NW + 1);
        a_prev = last_acc;
        expect_window(m, 14, mk_window(14, 0), 1'b0, 1'b0, -1, "rr14");
        expect_accept(m, 0, "rr0b");
        chk("rr0b_period", last_acc - a_prev, NW + 1);
        expect_window('0, 0, mk_window(0, 0), 1'b0, 1'b0, -1, "rr0b");
        step();
        bus.window_valid = '0;
        #1;
        chk("idle_wready", bus.window_ready, 0);
        chk("idle_wvalid", bus.word_valid, 0);

        // Level 14 served, then 14 and 2 pending: wrap grants 2 first; level 2 streamed with stalls.
        expect_accept(LV'(1 << 14), 14, "w14");
        m = LV'((1 << 14) | (1 << 2));
        expect_window(m, 14, mk_window(14, 0), 1'b0, 1'b0, -1, "w14");
        expect_accept(m, 2, "wrap2");
        expect_window(LV'(1 << 14), 2, mk_window(2, 0), 1'b1, 1'b0, -1, "stall2");
        expect_accept(LV'(1 << 14), 14, "wrap14");
        expect_window('0, 14, mk_window(14, 0), 1'b0, 1'b0, -1, "wrap14");

        // Level 3 (new data) moves ptr to 4; level 5 is then cut off by reset at word 10.
        expect_accept(LV'(1 << 3), 3, "l3");
        expect_window('0, 3, mk_window(3, 9), 1'b0, 1'b0, -1, "l3");
        expect_accept(LV'(1 << 5), 5, "l5");
        expect_window('0, 5, mk_window(5, 0), 1'b0, 1'b0, 10, "l5");
        step();
        bus.window_valid = '0;
        rst = 1'b1;
        #1;
        chk("arst_wvalid", bus.word_valid, 0);
        chk("arst_level",  bus.word_level, 0);
        chk("arst_first",  bus.word_first, 0);
        chk("arst_wready", bus.window_ready, 0);
        step();
        step();
        rst = 1'b0;
        m = LV'((1 << 2) | (1 << 5));
        expect_accept(m, 2, "post2");
        expect_window(LV'(1 << 5), 2, mk_window(2, 0), 1'b0, 1'b0, -1, "post2");
        expect_accept(LV'(1 << 5), 5, "post5");
        expect_window('0, 5, mk_window(5, 0), 1'b0, 1'b0, -1, "post5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/window_serializer.md
# window_serializer

Downstream of the HOG pyramid top level: accepts up to LEVELS parallel detection windows, each on its own valid/ready handshake, and funnels them into one word-serial stream for the classifier. A round-robin arbiter picks one pending level, captures its whole window into a local buffer, then emits it WORD_WIDTH bits at a time with level tag and first/last markers. One window is in flight at a time.

## Interface
- WINDOW_WIDTH, 1152 (32*36), bits per detection window; must be a multiple of WORD_WIDTH
- LEVELS, 15, number of pyramid levels / input channels
- WORD_WIDTH, 32, output word width
- NUM_WORDS, WINDOW_WIDTH/WORD_WIDTH (36), words per window (derived)
- LEVEL_W, max(1, clog2(LEVELS)), width of level tag (derived)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- window_valid  in  LEVELS  per-level window valid
- detection_window  in  LEVELS*WINDOW_WIDTH  level i at [i*WINDOW_WIDTH +: WINDOW_WIDTH]
- window_ready  out  LEVELS  per-level ready, at most one bit high
- word_out  out  WORD_WIDTH  serialized window word
- word_valid  out  1  word_out valid
- word_ready  in  1  consumer accepts word
- word_level  out  LEVEL_W  source level of current window
- word_first  out  1  high on word 0
- word_last  out  1  high on word NUM_WORDS-1

## Operation
- States: IDLE, SEND.
- IDLE: grant = first level with window_valid set, searching from ptr upward, wrapping LEVELS-1 -> 0. window_ready = one-hot(grant) when any valid, else 0; combinational from window_valid and ptr in IDLE only, all zero in SEND.
- Accept when window_valid[g] & window_ready[g]: capture detection_window slice g into buffer, word_level <= g, word index <= 0, go to SEND.
- SEND: word_valid = 1; word_out = buffer[idx*WORD_WIDTH +: WORD_WIDTH]; word_first = (idx==0); word_last = (idx==NUM_WORDS-1).
- Transfer on word_valid & word_ready: idx += 1. On the transfer with word_last: ptr <= (g==LEVELS-1) ? 0 : g+1, go to IDLE.
- Without word_ready, word_out, word_level, word_first and word_last hold stable.
- Level not granted keeps window_valid; no data lost. Upstream must not make valid depend on ready.
- Buffer is written only on accept; input changes during SEND are ignored.

## Timing
- Reset values: state IDLE, ptr 0, idx 0, word_valid 0, word_out 0, word_level 0, word_first 0, word_last 0, window_ready 0, buffer 0.
- Accept in cycle N -> word 0 valid in cycle N+1.
- Full-rate consumer: NUM_WORDS cycles in SEND, then 1 IDLE cycle. Window period NUM_WORDS+1 cycles (37 at defaults).
- Last-word transfer and a new window_valid in the same cycle: the new window is not accepted until the following IDLE cycle.
- Round robin: once granted, a level has lowest priority until every other pending level has been served.
- Reset asserted mid-SEND: immediate return to reset values. The partial window is dropped and is not resumed after reset.
- LEVELS=1: LEVEL_W=1, word_level always 0, ptr stays 0.

## Test plan
- Single window on level 0 with word i = i, word_ready tied 1 -> window_ready[0] pulses one cycle; 36 words 0..35 on consecutive cycles; word_first on word 0, word_last on word 35, word_level=0.
- Levels 0, 3 and 14 valid simultaneously and held -> windows out in order 0, 3, 14, then 0 again. Each window is 37 cycles apart; window_ready is never multi-hot.
- Level 14 served, then levels 14 and 2 valid -> level 2 granted first (wrap), then 14.
- word_ready toggled 1,0,0,1 pseudo-randomly -> word_out and tags stable while stalled; all 36 words in order with no duplicates or drops.
- rst pulsed at word 10 of a level-5 window -> word_valid=0 asynchronously; after release the next grant searches from level 0 and no stale words appear.
- Input data changed during SEND -> output matches the data captured at accept.
